// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, taken-branch flushes and fixed-latency
// data-memory freezes, plus saturating stall/flush performance counters.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd_addr,
  input  logic             ex_branch_taken,
  input  logic             ex_mem_mem_access,
  input  logic             perf_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_flush,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned      LatW    = $clog2(MEM_LAT + 1);
  localparam logic [LatW-1:0]  LatLast = LatW'(MEM_LAT - 1);

  logic [LatW-1:0]  lat_cnt_q, lat_cnt_d;
  logic             mem_busy_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             mem_stall, load_use, rs1_hit, rs2_hit;
  logic             stall_inc, flush_inc;

  // With MEM_LAT==1 lat_cnt never leaves 0 and LatLast is 0, so mem_stall stays low.
  assign mem_stall = ex_mem_mem_access && (lat_cnt_q != LatLast);

  assign rs1_hit  = id_uses_rs1 && (id_rs1_addr == id_ex_rd_addr);
  assign rs2_hit  = id_uses_rs2 && (id_rs2_addr == id_ex_rd_addr);
  assign load_use = id_ex_mem_read && (id_ex_rd_addr != 5'd0) && (rs1_hit || rs2_hit);

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_flush = 1'b0;
    if (mem_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // The dependent instruction of any load-use is squashed here, so no bubble is needed.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Release cycle and idle both return to 0, so a following access pays full latency.
  assign lat_cnt_d = mem_stall ? (lat_cnt_q + LatW'(1)) : '0;

  assign stall_inc = mem_stall || (load_use && !ex_branch_taken);
  assign flush_inc = ex_branch_taken && !mem_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_q  <= '0;
      mem_busy_q <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      lat_cnt_q  <= lat_cnt_d;
      mem_busy_q <= (lat_cnt_d != '0);
      if (perf_clr) begin
        stall_q <= '0;
        flush_q <= '0;
      end else begin
        if (stall_inc && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
        if (flush_inc && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign mem_busy     = mem_busy_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule
